pulse_period_monitor: RTL and testbench

PULSE_PERIOD_MONITOR -- requirements
Module: pulse_period_monitor

---
 rtl/pulse_period_monitor_if.sv | 34 +++
 rtl/pulse_period_monitor.sv | 122 ++++++++++++
 tb/tb_pulse_period_monitor.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pulse_period_monitor_if.sv
`default_nettype none
// ============================================================================
// pulse_period_monitor_if : pulse input and measurement/status outputs
// Rev 1.0
// ============================================================================
interface pulse_period_monitor_if #(
  parameter int CNT_W = 8
);
  logic             pulse_in;
  logic             period_valid;
  logic [CNT_W-1:0] period_out;
  logic             locked;
  logic             err_early;
  logic             err_late;

  modport master (
    output pulse_in,
    input  period_valid,
    input  period_out,
    input  locked,
    input  err_early,
    input  err_late
  );

  modport slave (
    input  pulse_in,
    output period_valid,
    output period_out,
    output locked,
    output err_early,
    output err_late
  );
endinterface
`default_nettype wire

// File: rtl/pulse_period_monitor.sv
`default_nettype none
// ============================================================================
// pulse_period_monitor : measures pulse period, flags early/late, tracks lock
// Rev 1.0
// ============================================================================
module pulse_period_monitor #(
  parameter int EXPECTED_PERIOD = 20,
  parameter int TOLERANCE       = 1,
  parameter int LOCK_COUNT      = 4,
  parameter int CNT_W           = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  pulse_period_monitor_if.slave  bus
);

  localparam int                 MATCH_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]   MIN_OK      = CNT_W'(EXPECTED_PERIOD - TOLERANCE);
  localparam logic [CNT_W-1:0]   MAX_OK      = CNT_W'(EXPECTED_PERIOD + TOLERANCE);
  localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [MATCH_W-1:0] r_match_cnt;
  logic               r_pulse_prev;
  logic [CNT_W-1:0]   r_period_out;
  logic               r_period_valid;
  logic               r_locked;
  logic               r_err_early;
  logic               r_err_late;

  logic               w_pulse_event;
  logic               w_is_early;
  logic               w_is_timeout;
  logic [MATCH_W-1:0] w_match_next;
  logic               w_lock_reached;

  assign w_pulse_event  = bus.pulse_in & ~r_pulse_prev;
  assign w_is_early     = (r_cnt < MIN_OK);
  assign w_is_timeout   = (r_cnt == MAX_OK);
  assign w_match_next   = (r_match_cnt == LOCK_TARGET) ? r_match_cnt
                                                       : r_match_cnt + MATCH_W'(1);
  assign w_lock_reached = (w_match_next == LOCK_TARGET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_match_cnt    <= '0;
      r_pulse_prev   <= 1'b0;
      r_period_out   <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_err_early    <= 1'b0;
      r_err_late     <= 1'b0;
    end else begin
      r_pulse_prev   <= bus.pulse_in;
      r_period_valid <= 1'b0;
      r_err_early    <= 1'b0;
      r_err_late     <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_pulse_event) begin
            r_cnt   <= CNT_ONE;
            r_state <= MEASURE;
          end
        end

        MEASURE, LOCKED: begin
          if (w_pulse_event) begin
            // A pulse landing exactly on the timeout count still counts as a match.
            r_cnt          <= CNT_ONE;
            r_period_out   <= r_cnt;
            r_period_valid <= 1'b1;
            if (w_is_early) begin
              r_err_early <= 1'b1;
              r_match_cnt <= '0;
              r_locked    <= 1'b0;
              r_state     <= MEASURE;
            end else begin
              r_match_cnt <= w_match_next;
              if (w_lock_reached) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end
          end else if (w_is_timeout) begin
            r_err_late  <= 1'b1;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
            r_state     <= IDLE;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_match_cnt <= '0;
          r_locked    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.period_valid = r_period_valid;
  assign bus.period_out   = r_period_out;
  assign bus.locked       = r_locked;
  assign bus.err_early    = r_err_early;
  assign bus.err_late     = r_err_late;

endmodule
`default_nettype wire

// File: tb/tb_pulse_period_monitor.sv
`default_nettype none
// ============================================================================
// tb_pulse_period_monitor : directed + randomized bench with timeline model
// Rev 1.0
// ============================================================================
module tb_pulse_period_monitor;

  localparam int E = 20;
  localparam int T = 1;
  localparam int L = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pulse_period_monitor_if #(.CNT_W(W)) bus ();

  pulse_period_monitor #(
    .EXPECTED_PERIOD (E),
    .TOLERANCE       (T),
    .LOCK_COUNT      (L),
    .CNT_W           (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: tracks absolute edge index of the last accepted pulse.
  int m_cyc;
  int m_last;
  int m_matches;
  bit m_armed;
  bit m_prev;
  bit m_locked;
  int m_period;
  bit m_valid;
  bit m_early;
  bit m_late;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_armed   = 1'b0;
    m_prev    = 1'b0;
    m_matches = 0;
    m_locked  = 1'b0;
    m_period  = 0;
    m_valid   = 1'b0;
    m_early   = 1'b0;
    m_late    = 1'b0;
  endtask

  task automatic model_edge(input bit p);
    bit evt;
    int elapsed;
    evt     = p && !m_prev;
    m_prev  = p;
    m_valid = 1'b0;
    m_early = 1'b0;
    m_late  = 1'b0;
    m_cyc++;
    if (!m_armed) begin
      if (evt) begin
        m_armed = 1'b1;
        m_last  = m_cyc;
      end
    end else begin
      elapsed = m_cyc - m_last;
      if (evt) begin
        m_period = elapsed;
        m_valid  = 1'b1;
        m_last   = m_cyc;
        if (elapsed < E - T) begin
          m_early   = 1'b1;
          m_matches = 0;
          m_locked  = 1'b0;
        end else begin
          if (m_matches < L) m_matches++;
          if (m_matches == L) m_locked = 1'b1;
        end
      end else if (elapsed == E + T) begin
        m_late    = 1'b1;
        m_armed   = 1'b0;
        m_matches = 0;
        m_locked  = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string where);
    chk({where, ".period_valid"}, int'(bus.period_valid), int'(m_valid));
    chk({where, ".period_out"},   int'(bus.period_out),   m_period);
    chk({where, ".locked"},       int'(bus.locked),       int'(m_locked));
    chk({where, ".err_early"},    int'(bus.err_early),    int'(m_early));
    chk({where, ".err_late"},     int'(bus.err_late),     int'(m_late));
  endtask

  task automatic step(input bit p);
    @(negedge clk);
    bus.pulse_in = p;
    model_edge(p);
    @(posedge clk);
    #1;
    compare_all("cyc");
  endtask

  // One pulse of width hi followed by low time; next call's pulse lands P cycles later.
  task automatic pulse_period(input int p_len, input int hi);
    for (int i = 0; i < p_len; i++) step(i < hi);
  endtask

  task automatic async_reset_mid();
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all("async_rst");
    #1 rst = 1'b0;
  endtask

  initial begin
    int p_len;
    int hi;
    int kind;

    rst          = 1'b1;
    bus.pulse_in = 1'b0;
    m_cyc        = 0;
    m_last       = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare_all("reset");
    @(negedge clk) rst = 1'b0;

    // Nominal train: lock on the 5th pulse.
    repeat (6) pulse_period(20, 1);
    chk("nominal_locked", int'(bus.locked), 1);

    // Early pulse while locked.
    pulse_period(15, 1);
    step(1);
    chk("early_strobe", int'(bus.err_early), 1);
    chk("early_period", int'(bus.period_out), 15);
    chk("early_unlock", int'(bus.locked), 0);
    for (int i = 1; i < 20; i++) step(0);

    // Re-lock, then let pulses stop.
    repeat (5) pulse_period(20, 1);
    repeat (25) step(0);
    repeat (3) pulse_period(20, 1);

    // Tolerance edges and just-too-late.
    pulse_period(19, 1);
    pulse_period(21, 1);
    pulse_period(22, 1);
    repeat (2) pulse_period(20, 1);

    // Wide pulses: one event per high run.
    repeat (6) pulse_period(20, 5);
    chk("wide_locked", int'(bus.locked), 1);

    // Asynchronous reset while locked, then fresh lock needs 5 pulses.
    async_reset_mid();
    chk("rst_locked_zero", int'(bus.locked), 0);
    repeat (6) pulse_period(20, 1);

    // Randomized mix of nominal, early and late periods.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      p_len = $urandom_range(3, 18);
      else if (kind == 1) p_len = $urandom_range(22, 30);
      else                p_len = $urandom_range(19, 21);
      hi = $urandom_range(1, (p_len - 1 < 5) ? p_len - 1 : 5);
      pulse_period(p_len, hi);
      if ($urandom_range(0, 99) == 0) async_reset_mid();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
